// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the FP unit: IEEE-754 single field widths,
// divider sequencing states and the unpacked-operand view.
package fp_pkg;

    localparam int unsigned BIAS   = 127;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned QBITS  = 26;
    localparam logic [30:0] MAX_FINITE = 31'h7F7FFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV   = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } fp_state_e;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W:0]   mant;
    } fp_operand_t;

    // Denormals get a zero hidden bit; callers treat exp==0 as zero anyway.
    function automatic fp_operand_t fp_unpack(input logic [31:0] x);
        fp_operand_t o;
        o.sign = x[31];
        o.exp  = x[30:23];
        o.mant = {(x[30:23] != 8'd0), x[22:0]};
        return o;
    endfunction

endpackage

// File: rtl/fp_div_32_if.sv
// Start/done handshake and operand/result bus between the FP control FSM and the divider.
interface fp_div_32_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        div_by_zero;

    modport master (
        output start, a, b,
        input  busy, done, result, div_by_zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, result, div_by_zero
    );
endinterface

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalised 24-bit mantissa, then pack with
// flush-to-zero on underflow and saturation to max finite on overflow.
module fp_round_rne
    import fp_pkg::*;
(
    input  logic [23:0]       m,
    input  logic              g,
    input  logic              s,
    input  logic signed [9:0] exp,
    input  logic              sign,
    output logic [31:0]       result
);

    logic              rnd_up_s;
    logic              carry_s;
    logic [22:0]       frac_s;
    logic [22:0]       frac_out_s;
    logic signed [9:0] exp_out_s;

    // Rounding increment, mantissa renormalisation and final packing.
    always_comb begin
        rnd_up_s = g & (s | m[0]);
        {carry_s, frac_s} = {1'b0, m[22:0]} + {23'd0, rnd_up_s};
        // Fraction wrapping with the hidden bit set means the mantissa reached 2^24.
        if (carry_s & m[23]) begin
            frac_out_s = 23'd0;
            exp_out_s  = exp + 10'sd1;
        end else begin
            frac_out_s = frac_s;
            exp_out_s  = exp;
        end

        if (exp_out_s <= 10'sd0) begin
            result = {sign, 31'd0};
        end else if (exp_out_s >= 10'sd255) begin
            result = {sign, MAX_FINITE};
        end else begin
            result = {sign, exp_out_s[7:0], frac_out_s};
        end
    end

endmodule

// File: rtl/fp_div_32.sv
// Sequential single-precision divider: radix-2 restoring mantissa division,
// one quotient bit per clock, followed by a single round-to-nearest-even cycle.
module fp_div_32
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    fp_div_32_if.slave  bus
);

    localparam logic signed [9:0] BIAS_S  = 10'(BIAS);
    localparam logic [4:0]        CNT_MAX = 5'(QBITS - 1);

    fp_state_e         state_q, state_d;
    logic              sign_q, sign_d;
    logic [23:0]       manb_q, manb_d;
    logic signed [9:0] e_q, e_d;
    logic [25:0]       q_q, q_d;
    logic [25:0]       rem_q, rem_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [31:0]       result_q, result_d;
    logic              dbz_q, dbz_d;

    fp_operand_t       op_a_s;
    fp_operand_t       op_b_s;
    logic              sign_s;
    logic [26:0]       trial_s;
    logic [25:0]       step_rem_s;

    logic [23:0]       rnd_m_s;
    logic              rnd_g_s;
    logic              rnd_s_s;
    logic signed [9:0] rnd_exp_s;
    logic [31:0]       rnd_result_s;

    // Normalise the quotient into mantissa, guard and sticky for the rounder.
    always_comb begin
        if (q_q[25]) begin
            rnd_m_s   = q_q[25:2];
            rnd_g_s   = q_q[1];
            rnd_s_s   = q_q[0] | (rem_q != 26'd0);
            rnd_exp_s = e_q;
        end else begin
            rnd_m_s   = q_q[24:1];
            rnd_g_s   = q_q[0];
            rnd_s_s   = (rem_q != 26'd0);
            rnd_exp_s = e_q - 10'sd1;
        end
    end

    fp_round_rne u_round (
        .m      (rnd_m_s),
        .g      (rnd_g_s),
        .s      (rnd_s_s),
        .exp    (rnd_exp_s),
        .sign   (sign_q),
        .result (rnd_result_s)
    );

    // Next-state and datapath update for the IDLE/DIV/ROUND/DONE sequence.
    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        manb_d   = manb_q;
        e_d      = e_q;
        q_d      = q_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        dbz_d    = dbz_q;

        op_a_s  = fp_unpack(bus.a);
        op_b_s  = fp_unpack(bus.b);
        sign_s  = op_a_s.sign ^ op_b_s.sign;
        trial_s = {1'b0, rem_q} - {3'b000, manb_q};
        // A borrow out of the trial subtraction restores the old remainder.
        step_rem_s = trial_s[26] ? rem_q : trial_s[25:0];

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sign_d = sign_s;
                    if (op_b_s.exp == 8'd0) begin
                        result_d = {sign_s, MAX_FINITE};
                        dbz_d    = 1'b1;
                        state_d  = DONE;
                    end else if (op_a_s.exp == 8'd0) begin
                        result_d = 32'd0;
                        dbz_d    = 1'b0;
                        state_d  = DONE;
                    end else begin
                        rem_d   = {2'b00, op_a_s.mant};
                        manb_d  = op_b_s.mant;
                        e_d     = $signed({2'b00, op_a_s.exp}) - $signed({2'b00, op_b_s.exp}) + BIAS_S;
                        q_d     = 26'd0;
                        cnt_d   = 5'd0;
                        state_d = DIV;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            DIV: begin
                q_d   = {q_q[24:0], ~trial_s[26]};
                rem_d = step_rem_s << 1;
                if (cnt_q == CNT_MAX) begin
                    state_d = ROUND;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            ROUND: begin
                result_d = rnd_result_s;
                dbz_d    = 1'b0;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and output registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            manb_q   <= 24'd0;
            e_q      <= 10'sd0;
            q_q      <= 26'd0;
            rem_q    <= 26'd0;
            cnt_q    <= 5'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 32'd0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            manb_q   <= manb_d;
            e_q      <= e_d;
            q_q      <= q_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.result      = result_q;
    assign bus.div_by_zero = dbz_q;

endmodule
